// File: rtl/dlgn_pkg.sv
// rtl/dlgn_pkg.sv - shared types and helpers for the logic-gate network output stage
package dlgn_pkg;

    typedef enum logic [1:0] {
        GSA_IDLE,
        GSA_SCAN,
        GSA_DONE
    } gsa_state_e;

    // Index width that stays at least one bit wide even for a single class
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dlgn_popcount.sv
// rtl/dlgn_popcount.sv - combinational popcount of a WIDTH-bit vector
module dlgn_popcount #(
    parameter int WIDTH = 8,
    localparam int OUT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [OUT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + OUT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/group_sum_argmax.sv
// rtl/group_sum_argmax.sv - iterative GroupSum + argmax, one class per cycle
// Optional score_o output enabled by GSA_SCORE_OUT_EN.
module group_sum_argmax
    import dlgn_pkg::*;
#(
    parameter int N_CLASSES      = 10,
    parameter int BITS_PER_CLASS = 8,
    localparam int CLS_W   = clog2_min1(N_CLASSES),
    localparam int SCORE_W = $clog2(BITS_PER_CLASS + 1),
    localparam int DATA_W  = N_CLASSES * BITS_PER_CLASS
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CLS_W-1:0]  class_o
`ifdef GSA_SCORE_OUT_EN
    ,
    output logic [SCORE_W-1:0] score_o
`endif
);

    localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(N_CLASSES - 1);

    gsa_state_e          state;
    logic [DATA_W-1:0]   data_q;
    logic [CLS_W-1:0]    idx;
    logic [CLS_W-1:0]    best_idx;
    logic [SCORE_W-1:0]  best_score;

    logic [BITS_PER_CLASS-1:0] slice;
    logic [SCORE_W-1:0]        pop;
    logic                      take;
    logic [SCORE_W-1:0]        cand_score;
    logic [CLS_W-1:0]          cand_idx;

    assign slice = data_q[idx*BITS_PER_CLASS +: BITS_PER_CLASS];

    dlgn_popcount #(
        .WIDTH (BITS_PER_CLASS)
    ) u_popcount (
        .bits  (slice),
        .count (pop)
    );

    // Strict compare so that ties keep the lowest class index
    always_comb begin
        take       = (idx == '0) || (pop > best_score);
        cand_score = take ? pop : best_score;
        cand_idx   = take ? idx : best_idx;
    end

    assign in_ready_o  = (state == GSA_IDLE);
    assign out_valid_o = (state == GSA_DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= GSA_IDLE;
            data_q     <= '0;
            idx        <= '0;
            best_idx   <= '0;
            best_score <= '0;
            class_o    <= '0;
`ifdef GSA_SCORE_OUT_EN
            score_o    <= '0;
`endif
        end else begin
            case (state)
                GSA_IDLE: begin
                    if (in_valid_i) begin
                        data_q     <= data_i;
                        idx        <= '0;
                        best_idx   <= '0;
                        best_score <= '0;
                        state      <= GSA_SCAN;
                    end
                end
                GSA_SCAN: begin
                    best_score <= cand_score;
                    best_idx   <= cand_idx;
                    if (idx == LAST_IDX) begin
                        class_o <= cand_idx;
`ifdef GSA_SCORE_OUT_EN
                        score_o <= cand_score;
`endif
                        state   <= GSA_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                GSA_DONE: begin
                    if (out_ready_i) begin
                        state <= GSA_IDLE;
                    end
                end
                default: state <= GSA_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_group_sum_argmax.sv
// tb/tb_group_sum_argmax.sv - self-checking bench for group_sum_argmax (N=4, 4 bits/class)
module tb_group_sum_argmax;

    localparam int N = 4;
    localparam int B = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  cls;
`ifdef GSA_SCORE_OUT_EN
    logic [2:0]  score;
`endif

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    int ph = -1;
    int exp_cls = 0;
    int exp_sc = 0;
    int cyc = 0;
    int n_acc = 0;

    group_sum_argmax #(
        .N_CLASSES      (N),
        .BITS_PER_CLASS (B)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .class_o     (cls)
`ifdef GSA_SCORE_OUT_EN
        ,
        .score_o     (score)
`endif
    );

    always #5 clk = ~clk;

    function automatic int ref_score(input logic [15:0] d);
        int best;
        best = -1;
        for (int c = 0; c < N; c++) begin
            if ($countones(d[c*B +: B]) > best) best = $countones(d[c*B +: B]);
        end
        return best;
    endfunction

    function automatic int ref_cls(input logic [15:0] d);
        int best;
        int bi;
        best = -1;
        bi = 0;
        for (int c = 0; c < N; c++) begin
            if ($countones(d[c*B +: B]) > best) begin
                best = $countones(d[c*B +: B]);
                bi = c;
            end
        end
        return bi;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction timeline: ph = edges since accept, result shown once ph reaches N
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= -1;
        end else if (ph < 0) begin
            if (in_valid) begin
                ph      <= 0;
                exp_cls <= ref_cls(data);
                exp_sc  <= ref_score(data);
                n_acc   <= n_acc + 1;
            end
        end else if (ph < N) begin
            ph <= ph + 1;
        end else if (out_ready) begin
            ph <= -1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", int'(in_ready), int'(ph < 0));
            chk("out_valid", int'(out_valid), int'(ph == N));
            if (ph == N) begin
                chk("class", int'(cls), exp_cls);
`ifdef GSA_SCORE_OUT_EN
                chk("score", int'(score), exp_sc);
`endif
            end
        end
    end

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_ready_wait"}, int'(in_ready), 1);
    endtask

    task automatic run_vec(input logic [15:0] d, input int ecls, input int esc, input string nm);
        int lat;
        @(posedge clk); #1;
        data = d;
        in_valid = 1'b1;
        wait_ready(nm);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, N + 1);
        chk({nm, "_class"}, int'(cls), ecls);
`ifdef GSA_SCORE_OUT_EN
        chk({nm, "_score"}, int'(score), esc);
`endif
        @(posedge clk); #1;
    endtask

    int acc_t[6];

    initial begin
        chk("ref_cls_0F13", ref_cls(16'h0F13), 2);
        chk("ref_score_0F13", ref_score(16'h0F13), 4);
        chk("ref_cls_tie", ref_cls(16'h3030), 1);
        chk("ref_score_tie", ref_score(16'h3030), 2);

        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_class", int'(cls), 0);
`ifdef GSA_SCORE_OUT_EN
        chk("rst_score", int'(score), 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        cmp_en = 1;

        run_vec(16'h0F13, 2, 4, "basic");
        run_vec(16'h3030, 1, 2, "tie");
        run_vec(16'h0000, 0, 0, "zeros");
        run_vec(16'hFFFF, 0, 4, "ones");

        // Backpressure: result held, second vector must wait for the handshake
        out_ready = 1'b0;
        @(posedge clk); #1;
        data = 16'h0F13;
        in_valid = 1'b1;
        @(posedge clk); #1;
        data = 16'h00F0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_class", int'(cls), 2);
            chk("bp_hold_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_second_class", int'(cls), 1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a scan
        data = 16'h0F13;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_vec(16'h0F00, 2, 4, "after_rst");

        // Back-to-back streaming
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data = 16'(($urandom & 32'hFFFF));
            wait_ready("b2b");
            @(posedge clk); #1;
            acc_t[k] = cyc;
            if (k > 0) chk("b2b_period", acc_t[k] - acc_t[k-1], N + 2);
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0: data = 16'h0000;
                1: data = 16'hFFFF;
                2: data = {2{8'($urandom)}};
                default: data = 16'($urandom);
            endcase
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_idle", int'(in_ready), 1);
        chk("accept_count_sane", int'(n_acc > 20), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
